dcache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache. It sits between the CPU's `dcache_*` request port and the DRAM controller, and is the responder for every CPU load and store. It returns load data combinationally on a hit. It raises `cache_miss_stall` while a line fill or store write-through is in progress.

---
 rtl/dcache_pkg.sv | 30 +++
 rtl/dcache_data_array.sv | 35 +++
 rtl/dcache_ctrl.sv | 160 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the direct-mapped write-through data cache.
`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 32
`endif

package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dcache_state_t;

  localparam logic DCACHE_STORE = 1'b1;

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int word_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  // Byte offset (2 bits), word select and index are carved off the bottom; the rest is tag.
  function automatic int tag_w(input int addr_w, input int lines, input int words_per_line);
    return addr_w - 2 - $clog2(lines) - $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/dcache_data_array.sv
// Line data storage: combinational read port, byte-enabled synchronous write port.
module dcache_data_array
  import dcache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  localparam int IDX_W         = idx_w(LINES),
  localparam int WORD_W        = word_w(WORDS_PER_LINE)
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  rd_index,
  input  logic [WORD_W-1:0] rd_word,
  output logic [31:0]       rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_be
);

  logic [31:0] mem_q [LINES*WORDS_PER_LINE];

  assign rd_data = mem_q[{rd_index, rd_word}];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem_q[{wr_index, wr_word}][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W         = `DRAM_ADDRESS_SIZE,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dcache_valid,
  input  logic              dcache_rw,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic [31:0]       dcache_data_in,
  input  logic [3:0]        dcache_byte_en,
  output logic [31:0]       dcache_data_out,
  output logic              cache_miss_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int IDX_W  = idx_w(LINES);
  localparam int WORD_W = word_w(WORDS_PER_LINE);
  localparam int TAG_W  = tag_w(ADDR_W, LINES, WORDS_PER_LINE);

  logic [WORD_W-1:0] req_word;
  logic [IDX_W-1:0]  req_index;
  logic [TAG_W-1:0]  req_tag;
  logic              addr_unused;

  assign req_word    = dcache_address[2 +: WORD_W];
  assign req_index   = dcache_address[2+WORD_W +: IDX_W];
  assign req_tag     = dcache_address[ADDR_W-1 -: TAG_W];
  assign addr_unused = ^dcache_address[1:0];

  dcache_state_t     state_q, state_d;
  logic [WORD_W-1:0] word_cnt_q, word_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic              tag_we;

  logic hit, is_store, mem_done, last_word;

  assign hit       = valid_q[req_index] && (tag_q[req_index] == req_tag);
  assign is_store  = (dcache_rw == DCACHE_STORE);
  assign mem_done  = mem_req_q && mem_ack;
  assign last_word = (word_cnt_q == WORD_W'(WORDS_PER_LINE - 1));

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    mem_req_d  = mem_req_q;
    valid_d    = valid_q;
    tag_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (dcache_valid) begin
          if (is_store) begin
            state_d   = WRITE;
            mem_req_d = 1'b1;
          end else if (!hit) begin
            // Claim the line for the new tag up front; it stays invalid until the last word lands.
            state_d            = FILL;
            mem_req_d          = 1'b1;
            word_cnt_d         = '0;
            valid_d[req_index] = 1'b0;
            tag_we             = 1'b1;
          end
        end
      end
      FILL: begin
        if (mem_done) begin
          word_cnt_d = word_cnt_q + WORD_W'(1);
          if (last_word) begin
            valid_d[req_index] = 1'b1;
            state_d            = IDLE;
            mem_req_d          = 1'b0;
          end
        end
      end
      WRITE: begin
        if (mem_done) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      mem_req_q  <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      mem_req_q  <= mem_req_d;
      valid_q    <= valid_d;
    end
  end

  // Tags need no reset: they are only trusted alongside a set valid bit.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_q[req_index] <= req_tag;
    end
  end

  logic              arr_we;
  logic [WORD_W-1:0] arr_word;
  logic [31:0]       arr_wdata;
  logic [3:0]        arr_be;
  logic [31:0]       arr_rdata;
  logic              in_fill;

  assign in_fill   = (state_q == FILL);
  assign arr_we    = mem_done && (in_fill || ((state_q == WRITE) && hit));
  assign arr_word  = in_fill ? word_cnt_q : req_word;
  assign arr_wdata = in_fill ? mem_rdata : dcache_data_in;
  assign arr_be    = in_fill ? 4'hF : dcache_byte_en;

  dcache_data_array #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_data_array (
    .clk      (clk),
    .rd_index (req_index),
    .rd_word  (req_word),
    .rd_data  (arr_rdata),
    .wr_en    (arr_we),
    .wr_index (req_index),
    .wr_word  (arr_word),
    .wr_data  (arr_wdata),
    .wr_be    (arr_be)
  );

  assign mem_req   = mem_req_q;
  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = in_fill ? {req_tag, req_index, word_cnt_q, 2'b00}
                             : {dcache_address[ADDR_W-1:2], 2'b00};
  assign mem_wdata = (state_q == WRITE) ? dcache_data_in : 32'h0;
  assign mem_wstrb = (state_q == WRITE) ? dcache_byte_en : 4'h0;

  assign cache_miss_stall = ((state_q == IDLE) && dcache_valid && (is_store || !hit))
                          || in_fill || (state_q == WRITE);

  assign dcache_data_out = ((state_q == IDLE) && dcache_valid && !is_store && hit)
                         ? arr_rdata : 32'h0;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios plus random traffic against a line/DRAM model.
module tb_dcache_ctrl;

  localparam int LINES      = 16;
  localparam int WPL        = 4;
  localparam int LINE_BYTES = WPL * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        dcache_valid;
  logic        dcache_rw;
  logic [31:0] dcache_address;
  logic [31:0] dcache_data_in;
  logic [3:0]  dcache_byte_en;
  logic [31:0] dcache_data_out;
  logic        cache_miss_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack   = 1'b0;

  dcache_ctrl #(
    .ADDR_W         (32),
    .LINES          (LINES),
    .WORDS_PER_LINE (WPL)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .dcache_valid     (dcache_valid),
    .dcache_rw        (dcache_rw),
    .dcache_address   (dcache_address),
    .dcache_data_in   (dcache_data_in),
    .dcache_byte_en   (dcache_byte_en),
    .dcache_data_out  (dcache_data_out),
    .cache_miss_stall (cache_miss_stall),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_wstrb        (mem_wstrb),
    .mem_rdata        (mem_rdata),
    .mem_ack          (mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] dram    [int];
  logic [31:0] ref_mem [int];
  bit          model_valid [LINES];
  int          model_tag   [LINES];

  int          ack_wait = 1;
  int          wait_cnt = 0;
  int          rd_q [$];
  int          wr_count = 0;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] default_word(input int a);
    logic [31:0] av;
    av = a;
    return {av[15:0] ^ 16'hC3A5, av[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] dram_rd(input int a);
    if (dram.exists(a)) return dram[a];
    return default_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return default_word(a);
  endfunction

  // DRAM responder: acks after ack_wait idle request cycles, logs every completed transaction.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt = 0;
    end else if (mem_req && mem_ack) begin
      wait_cnt = 0;
      if (mem_we) begin
        wr_count++;
        wr_addr = mem_addr;
        wr_data = mem_wdata;
        wr_strb = mem_wstrb;
        dram[int'(mem_addr)] = merge(dram_rd(int'(mem_addr)), mem_wdata, mem_wstrb);
      end else begin
        rd_q.push_back(int'(mem_addr));
      end
    end else if (mem_req) begin
      wait_cnt++;
    end
  end

  always @(negedge clk) begin
    #1;
    mem_ack   = mem_req && (wait_cnt >= ack_wait);
    mem_rdata = mem_ack ? dram_rd(int'(mem_addr)) : 32'h0;
  end

  // One CPU access, called at a negedge; returns at a negedge with dcache_valid low.
  task automatic applyStimulus(input bit rw, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input int wait_cycles);
    int          line, idx, tg, stall_cycles, exp_stall, n;
    bit          exp_hit;
    logic [31:0] got, line_base, waddr;
    line      = int'(addr) / LINE_BYTES;
    idx       = line % LINES;
    tg        = line / LINES;
    line_base = line * LINE_BYTES;
    waddr     = {addr[31:2], 2'b00};
    exp_hit   = model_valid[idx] && (model_tag[idx] == tg);
    ack_wait  = wait_cycles;
    rd_q.delete();
    wr_count  = 0;

    dcache_valid   = 1'b1;
    dcache_rw      = rw;
    dcache_address = addr;
    dcache_data_in = wdata;
    dcache_byte_en = be;
    stall_cycles   = 0;
    for (int c = 0; c < 100; c++) begin
      #2;
      if (!cache_miss_stall) break;
      stall_cycles++;
      @(negedge clk);
    end
    got = dcache_data_out;
    @(negedge clk);
    dcache_valid = 1'b0;
    @(negedge clk);

    if (rw) exp_stall = 2 + wait_cycles;
    else    exp_stall = exp_hit ? 0 : 1 + WPL * (wait_cycles + 1);
    checkOutput(rw ? "store_stall" : "load_stall", stall_cycles, exp_stall);

    if (!rw) begin
      checkOutput("load_data", got, ref_rd(int'(waddr)));
      checkOutput("load_reads", rd_q.size(), exp_hit ? 0 : WPL);
      checkOutput("load_writes", wr_count, 0);
      n = (rd_q.size() < WPL) ? rd_q.size() : WPL;
      if (!exp_hit) for (int i = 0; i < n; i++) checkOutput("fill_addr", rd_q[i], line_base + 4*i);
      if (!exp_hit) begin
        model_valid[idx] = 1'b1;
        model_tag[idx]   = tg;
      end
    end else begin
      checkOutput("store_writes", wr_count, 1);
      checkOutput("store_reads", rd_q.size(), 0);
      checkOutput("store_dout", got, 32'h0);
      if (wr_count > 0) begin
        checkOutput("store_addr", wr_addr, waddr);
        checkOutput("store_strb", {28'h0, wr_strb}, {28'h0, be});
        checkOutput("store_data", wr_data, wdata);
      end
      ref_mem[int'(waddr)] = merge(ref_rd(int'(waddr)), wdata, be);
    end
  endtask

  initial begin
    reset          = 1'b1;
    dcache_valid   = 1'b0;
    dcache_rw      = 1'b0;
    dcache_address = 32'h0;
    dcache_data_in = 32'h0;
    dcache_byte_en = 4'h0;
    for (int i = 0; i < LINES; i++) begin
      model_valid[i] = 1'b0;
      model_tag[i]   = 0;
    end
    for (int i = 0; i < WPL; i++) begin
      dram[32'h40 + 4*i]    = 32'hA0 + i;
      ref_mem[32'h40 + 4*i] = 32'hA0 + i;
    end

    @(negedge clk);
    @(negedge clk);
    #2;
    checkOutput("reset_mem_req", {31'h0, mem_req}, 32'h0);
    checkOutput("reset_stall", {31'h0, cache_miss_stall}, 32'h0);
    checkOutput("reset_dout", dcache_data_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #2;
    checkOutput("idle_stall", {31'h0, cache_miss_stall}, 32'h0);
    @(negedge clk);

    $display("[TB] cold load, hit, partial store");
    applyStimulus(1'b0, 32'h40, 32'h0, 4'h0, 1);
    applyStimulus(1'b0, 32'h44, 32'h0, 4'h0, 1);
    applyStimulus(1'b1, 32'h44, 32'h0000_5500, 4'b0010, 1);
    applyStimulus(1'b0, 32'h44, 32'h0, 4'h0, 1);
    checkOutput("merged_word", ref_rd(32'h44), 32'h0000_55A1);

    $display("[TB] store miss without allocation");
    applyStimulus(1'b1, 32'h1000, 32'hDEAD_BEEF, 4'hF, 1);
    applyStimulus(1'b0, 32'h1000, 32'h0, 4'h0, 1);

    $display("[TB] conflict eviction");
    applyStimulus(1'b0, 32'h40, 32'h0, 4'h0, 2);
    applyStimulus(1'b0, 32'h40 + LINES*WPL*4, 32'h0, 4'h0, 2);
    applyStimulus(1'b0, 32'h40, 32'h0, 4'h0, 0);

    $display("[TB] reset during fill");
    ack_wait       = 0;
    dcache_valid   = 1'b1;
    dcache_rw      = 1'b0;
    dcache_address = 32'h240;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset        = 1'b1;
    dcache_valid = 1'b0;
    #1;
    checkOutput("rst_fill_mem_req", {31'h0, mem_req}, 32'h0);
    checkOutput("rst_fill_stall", {31'h0, cache_miss_stall}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < LINES; i++) model_valid[i] = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 32'h240, 32'h0, 4'h0, 0);

    $display("[TB] zero-wait DRAM");
    applyStimulus(1'b0, 32'h80, 32'h0, 4'h0, 0);
    applyStimulus(1'b1, 32'h84, 32'h1234_5678, 4'b1001, 0);
    applyStimulus(1'b0, 32'h84, 32'h0, 4'h0, 0);

    $display("[TB] random traffic");
    for (int k = 0; k < 200; k++) begin
      logic [31:0] a;
      a = $urandom_range(0, LINES*WPL*4 - 1) * 4 + $urandom_range(0, 3);
      applyStimulus(1'($urandom_range(0, 2) == 0), a, $urandom, 4'($urandom),
                    int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL timeout: got=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
